// File: rtl/led_pattern_ctrl.sv
// LED pattern engine: programmable tick divider, debounced mode button and an
// N-bit pattern register stepping through binary, chase, bounce and blink modes.
module led_pattern_ctrl #(
   parameter int NUM_LEDS    = 8,
   parameter int DIV_WIDTH   = 24,
   parameter int DBNC_CYCLES = 500000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 enable,
   input  logic                 btn_n,
   output logic [NUM_LEDS-1:0]  led,
   output logic [1:0]           mode,
   output logic                 tick
);

   typedef enum logic [1:0] {
      MODE_BIN    = 2'd0,
      MODE_CHASE  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   localparam int DBW = $clog2(DBNC_CYCLES + 1);
   localparam logic [DBW-1:0]      DBNC_LAST = DBW'(DBNC_CYCLES - 1);
   localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1);
   localparam logic [NUM_LEDS-1:0] LED_TOP   = LED_ONE << (NUM_LEDS - 1);

   logic [DIV_WIDTH-1:0] cnt_reg;
   logic                 tick_reg;
   logic                 sync1_reg, sync2_reg;
   logic                 db_reg, db_d_reg;
   logic [DBW-1:0]       dbnc_cnt_reg;
   logic                 press;

   logic [NUM_LEDS-1:0]  led_reg, led_next;
   mode_t                mode_reg, mode_next;
   logic                 dir_reg, dir_next;   // 0 = up (towards MSB), 1 = down
   logic [1:0]           mode_inc;

   // Tick divider: >= compare so lowering div below cnt fires on the next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg  <= '0;
         tick_reg <= 1'b0;
      end else if (!enable) begin
         tick_reg <= 1'b0;
      end else if (cnt_reg >= div) begin
         cnt_reg  <= '0;
         tick_reg <= 1'b1;
      end else begin
         cnt_reg  <= cnt_reg + DIV_WIDTH'(1);
         tick_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg    <= 1'b1;
         sync2_reg    <= 1'b1;
         db_reg       <= 1'b1;
         db_d_reg     <= 1'b1;
         dbnc_cnt_reg <= '0;
      end else begin
         sync1_reg <= btn_n;
         sync2_reg <= sync1_reg;
         db_d_reg  <= db_reg;
         if (sync2_reg == db_reg) begin
            dbnc_cnt_reg <= '0;
         end else if (dbnc_cnt_reg == DBNC_LAST) begin
            db_reg       <= sync2_reg;
            dbnc_cnt_reg <= '0;
         end else begin
            dbnc_cnt_reg <= dbnc_cnt_reg + DBW'(1);
         end
      end
   end

   // Falling edge of the debounced level, seen one cycle after it settles.
   assign press    = db_d_reg & ~db_reg;
   assign mode_inc = mode_reg + 2'd1;

   always_comb begin
      led_next  = led_reg;
      mode_next = mode_reg;
      dir_next  = dir_reg;
      if (press) begin
         mode_next = mode_t'(mode_inc);
         dir_next  = 1'b0;
         if (mode_next == MODE_BIN || mode_next == MODE_BLINK)
            led_next = '0;
         else
            led_next = LED_ONE;
      end else if (tick_reg && enable) begin
         case (mode_reg)
            MODE_BIN:   led_next = led_reg + LED_ONE;
            MODE_CHASE: led_next = (led_reg << 1) | (led_reg >> (NUM_LEDS - 1));
            MODE_BOUNCE: begin
               if (NUM_LEDS == 1) begin
                  led_next = LED_ONE;
               end else if (!dir_reg) begin
                  led_next = led_reg << 1;
                  if (led_next == LED_TOP) dir_next = 1'b1;
               end else begin
                  led_next = led_reg >> 1;
                  if (led_next == LED_ONE) dir_next = 1'b0;
               end
            end
            default:    led_next = ~led_reg;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_reg  <= '0;
         mode_reg <= MODE_BIN;
         dir_reg  <= 1'b0;
      end else begin
         led_reg  <= led_next;
         mode_reg <= mode_next;
         dir_reg  <= dir_next;
      end
   end

   assign led  = led_reg;
   assign mode = mode_reg;
   assign tick = tick_reg;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: divider timing, debounce, all four
// patterns, press/tick collision, hold and asynchronous reset.
module tb_led_pattern_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] div;
   logic       enable;
   logic       btn_n;
   logic [7:0] led8;
   logic [1:0] mode8;
   logic       tick8;
   logic [0:0] led1;
   logic [1:0] mode1;
   logic       tick1;

   int checks = 0;
   int errors = 0;

   led_pattern_ctrl #(.NUM_LEDS(8), .DIV_WIDTH(8), .DBNC_CYCLES(4)) u_dut (
      .clk(clk), .rst(rst), .div(div), .enable(enable), .btn_n(btn_n),
      .led(led8), .mode(mode8), .tick(tick8)
   );

   led_pattern_ctrl #(.NUM_LEDS(1), .DIV_WIDTH(8), .DBNC_CYCLES(4)) u_dut1 (
      .clk(clk), .rst(rst), .div(div), .enable(enable), .btn_n(btn_n),
      .led(led1), .mode(mode1), .tick(tick1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] bounce_seq [15];
   logic [7:0] exp_led;

   initial begin
      bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      rst = 1'b1; div = 8'd3; enable = 1'b1; btn_n = 1'b1;
      #1;
      check("reset_led", led8, 0);
      check("reset_mode", mode8, 0);
      check("reset_tick", tick8, 0);
      check("reset_led1", led1, 0);
      cyc(2);
      rst = 1'b0;

      // Binary count, tick every 4 cycles, wrap after 256 steps
      for (int i = 0; i <= 256; i++) begin
         cyc(4);
         check("bin_tick", tick8, 1);
         check("bin_led", led8, i % 256);
         $display("bin tick %0d led=%02h", i, led8);
      end

      // div=0: tick every cycle
      div = 8'd0;
      for (int k = 1; k <= 5; k++) begin
         cyc(1);
         check("div0_tick", tick8, 1);
         check("div0_led", led8, k);
      end
      div = 8'd3;
      cyc(2);
      div = 8'd100;
      cyc(98);
      check("div_raise_no_tick", tick8, 0);
      check("div_raise_led", led8, 6);
      cyc(1);
      check("div_raise_tick", tick8, 1);
      cyc(50);
      div = 8'd5;
      cyc(1);
      check("div_drop_tick", tick8, 1);
      check("div_drop_led", led8, 7);
      $display("divider raise/drop done led=%02h", led8);

      // Debounce: short glitch ignored, long press accepted
      enable = 1'b0;
      btn_n  = 1'b0;
      cyc(3);
      btn_n = 1'b1;
      cyc(10);
      check("glitch_mode", mode8, 0);
      check("glitch_led", led8, 7);
      btn_n = 1'b0;
      cyc(6);
      check("press_pending_mode", mode8, 0);
      cyc(1);
      check("press_mode", mode8, 1);
      check("press_led", led8, 1);
      check("press_mode_n1", mode1, 1);
      cyc(13);
      btn_n = 1'b1;
      cyc(10);
      check("release_mode", mode8, 1);
      check("release_led", led8, 1);
      $display("debounce done mode=%0d led=%02h", mode8, led8);

      // Bounce
      btn_n = 1'b0;
      cyc(7);
      check("bounce_mode", mode8, 2);
      check("bounce_init", led8, 1);
      btn_n = 1'b1;
      cyc(10);
      div = 8'd0;
      enable = 1'b1;
      cyc(1);
      check("bounce_first_tick", tick8, 1);
      check("bounce_first_led", led8, 1);
      for (int k = 0; k < 15; k++) begin
         cyc(1);
         check("bounce_led", led8, bounce_seq[k]);
         check("bounce_onehot", $onehot(led8), 1);
         check("bounce_n1", led1, 1);
         $display("bounce step %0d led=%02h", k, led8);
      end

      // Press coincident with tick into BLINK
      btn_n = 1'b0;
      cyc(6);
      check("blink_pending_mode", mode8, 2);
      cyc(1);
      check("blink_mode", mode8, 3);
      check("blink_init", led8, 0);
      check("blink_press_tick", tick8, 1);
      btn_n = 1'b1;
      cyc(1);
      check("blink_ff", led8, 8'hff);
      cyc(1);
      check("blink_00", led8, 0);
      cyc(1);
      check("blink_ff2", led8, 8'hff);
      cyc(7);
      btn_n = 1'b0;
      cyc(7);
      check("wrap_mode", mode8, 0);
      btn_n = 1'b1;
      cyc(10);

      // CHASE, including the 80 -> 01 rotate
      btn_n = 1'b0;
      cyc(7);
      check("chase_mode", mode8, 1);
      check("chase_init", led8, 1);
      check("chase_press_tick", tick8, 1);
      btn_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         exp_led = 8'd1 << (k % 8);
         check("chase_led", led8, exp_led);
         check("chase_onehot", $onehot(led8), 1);
         $display("chase step %0d led=%02h", k, led8);
      end

      // Hold with enable low
      enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc(1);
         check("hold_led", led8, 1);
         check("hold_tick", tick8, 0);
      end
      enable = 1'b1;
      cyc(1);
      check("resume_tick", tick8, 1);
      check("resume_led", led8, 1);
      cyc(1);
      check("resume_step", led8, 2);

      // Asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_led", led8, 0);
      check("async_rst_mode", mode8, 0);
      check("async_rst_tick", tick8, 0);
      $display("async reset led=%02h mode=%0d tick=%0d", led8, mode8, tick8);
      cyc(2);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
